izh_neuron_scheduler: RTL and testbench

// - Time-multiplexes one shared Izhikevich update datapath across N_NEURONS neurons.
// - Holds per-neuron state (v, u) and input current (I) in a small register file.
// - On each simulation tick, sweeps neurons 0..N_NEURONS-1 in order: issues the stored state to the datapath, writes back the result, reports spikes.
// - Sits between the tt_um_neuron top-level I/O (tick/config/spike pins) and the izh update datapath.

---
 rtl/izh_pkg.sv | 17 +
 rtl/izh_state_rf.sv | 61 ++++++
 rtl/izh_neuron_scheduler.sv | 126 ++++++++++++
 tb/tb_izh_neuron_scheduler.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/izh_pkg.sv
// Shared width, reset constants and sweep state encoding for the Izhikevich
// neuron scheduler and its state register file.
package izh_pkg;

  localparam int W = 16;

  // Q8.8 resting values: v = -65.0, u = -13.0
  localparam logic signed [W-1:0] V_RST = W'(-65 * 256);
  localparam logic signed [W-1:0] U_RST = W'(-13 * 256);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/izh_state_rf.sv
// Per-neuron {v, u, I} storage: synchronous state and current write ports,
// one asynchronous read port. Out-of-range addresses never match an entry.
module izh_state_rf
  import izh_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int IDX_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st_we,
  input  logic [IDX_W-1:0]     st_addr,
  input  logic signed [W-1:0]  st_v,
  input  logic signed [W-1:0]  st_u,
  input  logic                 cur_we,
  input  logic [IDX_W-1:0]     cur_addr,
  input  logic signed [W-1:0]  cur_i,
  input  logic [IDX_W-1:0]     rd_addr,
  output logic signed [W-1:0]  rd_v,
  output logic signed [W-1:0]  rd_u,
  output logic signed [W-1:0]  rd_i
);

  logic signed [W-1:0] v_q [N_NEURONS];
  logic signed [W-1:0] u_q [N_NEURONS];
  logic signed [W-1:0] i_q [N_NEURONS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        v_q[n] <= V_RST;
        u_q[n] <= U_RST;
        i_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < N_NEURONS; n++) begin
        if (st_we && st_addr == IDX_W'(n)) begin
          v_q[n] <= st_v;
          u_q[n] <= st_u;
        end
        if (cur_we && cur_addr == IDX_W'(n)) begin
          i_q[n] <= cur_i;
        end
      end
    end
  end

  always_comb begin
    rd_v = '0;
    rd_u = '0;
    rd_i = '0;
    for (int n = 0; n < N_NEURONS; n++) begin
      if (rd_addr == IDX_W'(n)) begin
        rd_v = v_q[n];
        rd_u = u_q[n];
        rd_i = i_q[n];
      end
    end
  end

endmodule

// File: rtl/izh_neuron_scheduler.sv
// Sweeps all neurons through one shared Izhikevich datapath per tick.
//   state | meaning
//   IDLE  | waiting for tick; no request outstanding
//   ISSUE | dp_valid high, payload of neuron idx held until dp_ready
//   WAIT  | request accepted, waiting for res_valid to write back
module izh_neuron_scheduler
  import izh_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_addr,
  input  logic signed [W-1:0]  cfg_current,
  output logic                 dp_valid,
  input  logic                 dp_ready,
  output logic [IDX_W-1:0]     dp_idx,
  output logic signed [W-1:0]  dp_v,
  output logic signed [W-1:0]  dp_u,
  output logic signed [W-1:0]  dp_i,
  input  logic                 res_valid,
  input  logic signed [W-1:0]  res_v,
  input  logic signed [W-1:0]  res_u,
  input  logic                 res_spike,
  output logic                 spike_valid,
  output logic [IDX_W-1:0]     spike_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    rd_addr;
  logic signed [W-1:0] rd_v, rd_u, rd_i;
  logic                wb_en;
  logic                last;

  // Read port looks ahead to the neuron that the next transition will latch.
  assign rd_addr = (state == WAIT) ? idx + IDX_W'(1) : '0;
  assign wb_en   = (state == WAIT) && res_valid;
  assign last    = (idx == IDX_W'(N_NEURONS - 1));
  assign dp_idx  = idx;

  izh_state_rf #(
    .N_NEURONS (N_NEURONS),
    .IDX_W     (IDX_W)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .st_we    (wb_en),
    .st_addr  (idx),
    .st_v     (res_v),
    .st_u     (res_u),
    .cur_we   (cfg_we),
    .cur_addr (cfg_addr),
    .cur_i    (cfg_current),
    .rd_addr  (rd_addr),
    .rd_v     (rd_v),
    .rd_u     (rd_u),
    .rd_i     (rd_i)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      dp_valid    <= 1'b0;
      dp_v        <= '0;
      dp_u        <= '0;
      dp_i        <= '0;
      spike_valid <= 1'b0;
      spike_idx   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      spike_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            state    <= ISSUE;
            idx      <= '0;
            dp_valid <= 1'b1;
            dp_v     <= rd_v;
            dp_u     <= rd_u;
            dp_i     <= rd_i;
            busy     <= 1'b1;
          end
        end
        ISSUE: begin
          if (tick) overrun <= 1'b1;
          if (dp_ready) begin
            state    <= WAIT;
            dp_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (tick) overrun <= 1'b1;
          if (res_valid) begin
            spike_valid <= res_spike;
            spike_idx   <= idx;
            if (last) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= ISSUE;
              idx      <= idx + IDX_W'(1);
              dp_valid <= 1'b1;
              dp_v     <= rd_v;
              dp_u     <= rd_u;
              dp_i     <= rd_i;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_izh_neuron_scheduler.sv
// Directed/randomized bench for izh_neuron_scheduler with an array-based
// model of neuron state and a cycle-driven datapath responder.
module tb_izh_neuron_scheduler;

  localparam int N = 4;
  localparam int IW = 2;
  localparam logic signed [15:0] M_V_RST = 16'(-65 * 256);
  localparam logic signed [15:0] M_U_RST = 16'(-13 * 256);

  logic clk = 1'b0;
  logic rst, tick, cfg_we, dp_ready, res_valid, res_spike;
  logic [IW-1:0] cfg_addr;
  logic signed [15:0] cfg_current, res_v, res_u;
  logic dp_valid, spike_valid, busy, done, overrun;
  logic [IW-1:0] dp_idx, spike_idx;
  logic signed [15:0] dp_v, dp_u, dp_i;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit exp_ovr = 1'b0;

  logic signed [15:0] m_v [N];
  logic signed [15:0] m_u [N];
  logic signed [15:0] m_i [N];

  izh_neuron_scheduler #(.N_NEURONS(N), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_current(cfg_current),
    .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_idx(dp_idx),
    .dp_v(dp_v), .dp_u(dp_u), .dp_i(dp_i),
    .res_valid(res_valid), .res_v(res_v), .res_u(res_u), .res_spike(res_spike),
    .spike_valid(spike_valid), .spike_idx(spike_idx),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_v[k] = M_V_RST;
      m_u[k] = M_U_RST;
      m_i[k] = '0;
    end
    exp_ovr = 1'b0;
  endtask

  task automatic cfg_write(input int a, input logic signed [15:0] val);
    cfg_we = 1'b1;
    cfg_addr = IW'(a);
    cfg_current = val;
    @(negedge clk);
    cfg_we = 1'b0;
    m_i[a] = val;
  endtask

  // spike_mode: <0 random spikes, otherwise only neuron == spike_mode fires.
  // tick_n: neuron during whose WAIT a stray tick is sent (<0 none).
  // rst_n: neuron during whose WAIT reset is asserted (<0 none).
  task automatic sweep(input int lat, input int stall, input int spike_mode,
                       input int tick_n, input bit tick_last, input int rst_n);
    int t0, wt;
    bit sp;
    logic signed [15:0] sv, su, snap_v, snap_u, snap_i, nv;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    t0 = cyc;
    for (int n = 0; n < N; n++) begin
      wt = 0;
      while (!dp_valid && wt < 20) begin
        @(negedge clk);
        wt++;
      end
      check("issue_latency", wt, 0);
      check("dp_idx", dp_idx, n);
      check("busy_sweep", busy, 1);
      check("done_mid", done, 0);
      check("dp_v", dp_v, m_v[n]);
      check("dp_u", dp_u, m_u[n]);
      check("dp_i", dp_i, m_i[n]);
      snap_v = dp_v; snap_u = dp_u; snap_i = dp_i;
      if (n == 0) begin
        for (int s = 0; s < stall; s++) begin
          dp_ready = 1'b0;
          if (s == 1) begin
            nv = 16'($urandom);
            cfg_write(0, nv);
          end else begin
            @(negedge clk);
          end
          check("stall_valid", dp_valid, 1);
          check("stall_v", dp_v, snap_v);
          check("stall_u", dp_u, snap_u);
          check("stall_i", dp_i, snap_i);
          check("stall_idx", dp_idx, 0);
        end
      end
      dp_ready = 1'b1;
      @(negedge clk);
      dp_ready = 1'b0;
      check("dp_drop", dp_valid, 0);
      check("spike_quiet", spike_valid, 0);
      for (int k = 0; k < lat; k++) begin
        if (n == tick_n && k == 0) begin
          tick = 1'b1;
          exp_ovr = 1'b1;
        end
        @(negedge clk);
        tick = 1'b0;
      end
      if (n == rst_n) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("rst_busy", busy, 0);
        check("rst_valid", dp_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_done", done, 0);
        res_valid = 1'b1; res_spike = 1'b1;
        res_v = 16'h1234; res_u = 16'h5678;
        @(negedge clk);
        res_valid = 1'b0; res_spike = 1'b0;
        check("late_spike", spike_valid, 0);
        check("late_valid", dp_valid, 0);
        check("late_busy", busy, 0);
        return;
      end
      sv = 16'($urandom);
      su = 16'($urandom);
      sp = (spike_mode < 0) ? bit'($urandom_range(0, 1)) : (n == spike_mode);
      res_valid = 1'b1; res_v = sv; res_u = su; res_spike = sp;
      if (tick_last && n == N - 1) begin
        tick = 1'b1;
        exp_ovr = 1'b1;
      end
      @(negedge clk);
      res_valid = 1'b0; res_spike = 1'b0; tick = 1'b0;
      check("spike_valid", spike_valid, sp);
      if (sp) check("spike_idx", spike_idx, n);
      m_v[n] = sv;
      m_u[n] = su;
    end
    check("done_pulse", done, 1);
    check("busy_end", busy, 0);
    check("sweep_len", cyc - t0, N * (2 + lat) + stall);
    check("overrun", overrun, exp_ovr);
    @(negedge clk);
    check("done_once", done, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", dp_valid, 0);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_current = '0;
    dp_ready = 1'b0; res_valid = 1'b0; res_spike = 1'b0; res_v = '0; res_u = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_dp_valid", dp_valid, 0);
    check("rst_dp_idx", dp_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_spike", spike_valid, 0);

    // reset values forwarded, latency-2 datapath, no spikes
    sweep(2, 0, 99, -1, 1'b0, -1);

    // current programmed while idle reaches neuron 2 only; only neuron 1 fires
    cfg_write(2, 16'sh0A00);
    sweep(2, 0, 1, -1, 1'b0, -1);

    // random currents, ready stall on neuron 0 with a write to its latched current
    for (int k = 0; k < N; k++) cfg_write(k, 16'($urandom));
    sweep(3, 5, -1, -1, 1'b0, -1);

    // stray tick mid-sweep, then a tick on the final write-back cycle
    sweep(1, 0, -1, 2, 1'b0, -1);
    sweep(2, 0, -1, -1, 1'b1, -1);
    sweep(0, 1, -1, -1, 1'b0, -1);

    // reset while waiting on neuron 2, then confirm state is back to reset values
    sweep(2, 0, -1, -1, 1'b0, 2);
    sweep(2, 0, -1, -1, 1'b0, -1);

    for (int r = 0; r < 6; r++) begin
      cfg_write($urandom_range(0, N - 1), 16'($urandom));
      sweep($urandom_range(0, 3), $urandom_range(0, 3), -1, -1, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
